// File: rtl/pipe_stall_ctrl_if.sv
// Hazard sources from the pipeline and stall/flush/divider controls back to it.
// master = pipeline side, slave = pipe_stall_ctrl.
interface pipe_stall_ctrl_if;
   logic [4:0] rsD;
   logic [4:0] rtD;
   logic [4:0] reg_writeE;
   logic       mem_to_regE;
   logic       div_reqE;
   logic       div_done;
   logic       data_reqM;
   logic       data_ok;
   logic       exceptM;
   logic       stallF;
   logic       stallD;
   logic       stallE;
   logic       stallM;
   logic       stallW;
   logic       flushD;
   logic       flushE;
   logic       flushM;
   logic       flushW;
   logic       div_go;
   logic       div_cancel;

   modport master (
      output rsD, rtD, reg_writeE, mem_to_regE, div_reqE, div_done,
             data_reqM, data_ok, exceptM,
      input  stallF, stallD, stallE, stallM, stallW,
             flushD, flushE, flushM, flushW, div_go, div_cancel
   );

   modport slave (
      input  rsD, rtD, reg_writeE, mem_to_regE, div_reqE, div_done,
             data_reqM, data_ok, exceptM,
      output stallF, stallD, stallE, stallM, stallW,
             flushD, flushE, flushM, flushW, div_go, div_cancel
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline (load-use, divider, SRAM waits, exceptions).
// Optional STALL_CNT_EN adds a 32-bit stall_cycles counter of cycles with stallF asserted.
module pipe_stall_ctrl #(
   parameter int DIV_ID_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   pipe_stall_ctrl_if.slave  ps
`ifdef STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   if (DIV_ID_W != 1) begin : g_div_id_chk
      $error("pipe_stall_ctrl: DIV_ID_W must be 1");
   end

   logic div_busy;
   logic div_fin;
   logic mem_fin;

   logic lw_hz;
   logic mem_st;
   logic div_st;
   logic ex;

   logic [4:0] stall;
   logic [3:0] flush;
   logic       go;
   logic       cancel;

   assign lw_hz  = ps.mem_to_regE && (ps.reg_writeE != 5'd0) &&
                   ((ps.reg_writeE == ps.rsD) || (ps.reg_writeE == ps.rtD));
   assign mem_st = ps.data_reqM && !ps.data_ok && !mem_fin;
   assign div_st = ps.div_reqE && !ps.div_done && !div_fin;
   // An exception must wait for any outstanding data access to finish.
   assign ex     = ps.exceptM && !mem_st;

   // stall = {F,D,E,M,W}, flush = {D,E,M,W}
   always_comb begin
      stall  = 5'b00000;
      flush  = 4'b0000;
      go     = 1'b0;
      cancel = 1'b0;
      if (!rst) begin
         if (ex) begin
            flush  = 4'b1111;
            cancel = div_busy;
         end else if (mem_st) begin
            stall = 5'b11111;
         end else if (div_st) begin
            stall = 5'b11100;
            flush = 4'b0010;
         end else if (lw_hz) begin
            stall = 5'b11000;
            flush = 4'b0100;
         end
         go = ps.div_reqE && !div_busy && !div_fin && !ex;
      end
   end

   assign ps.stallF     = stall[4];
   assign ps.stallD     = stall[3];
   assign ps.stallE     = stall[2];
   assign ps.stallM     = stall[1];
   assign ps.stallW     = stall[0];
   assign ps.flushD     = flush[3];
   assign ps.flushE     = flush[2];
   assign ps.flushM     = flush[1];
   assign ps.flushW     = flush[0];
   assign ps.div_go     = go;
   assign ps.div_cancel = cancel;

   // Completion tracking: a result arriving while the stage is held is remembered until it advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_busy <= 1'b0;
         div_fin  <= 1'b0;
         mem_fin  <= 1'b0;
      end else begin
         if (ps.div_done || ex) begin
            div_busy <= 1'b0;
         end else if (go) begin
            div_busy <= 1'b1;
         end

         if (ex || !stall[2]) begin
            div_fin <= 1'b0;
         end else if (ps.div_done) begin
            div_fin <= 1'b1;
         end

         if (ex || !stall[1]) begin
            mem_fin <= 1'b0;
         end else if (ps.data_ok) begin
            mem_fin <= 1'b1;
         end
      end
   end

`ifdef STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'd0;
      end else if (stall[4]) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed hazard scenarios plus random traffic,
// checked against a behavioural model of the hazard rules.
module tb_pipe_stall_ctrl;

   logic clk;
   logic rst;

   pipe_stall_ctrl_if ps ();

`ifdef STALL_CNT_EN
   logic [31:0] stall_cycles;
   pipe_stall_ctrl #(.DIV_ID_W(1)) dut (.clk(clk), .rst(rst), .ps(ps), .stall_cycles(stall_cycles));
`else
   pipe_stall_ctrl #(.DIV_ID_W(1)) dut (.clk(clk), .rst(rst), .ps(ps));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic [4:0] rsD;
      logic [4:0] rtD;
      logic [4:0] reg_writeE;
      logic       mem_to_regE;
      logic       div_reqE;
      logic       div_done;
      logic       data_reqM;
      logic       data_ok;
      logic       exceptM;
   } stim_t;

   // ctl = {stallF,stallD,stallE,stallM,stallW,flushD,flushE,flushM,flushW,div_go,div_cancel}
   typedef struct packed {
      logic [10:0] ctl;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Model state: divide instruction in E is idle (0), running (1), or holding its result (2).
   int          div_state = 0;
   bit          mem_held  = 0;
   logic [31:0] cnt_m     = 32'd0;
   stim_t       prev;
   logic [10:0] prev_ctl;
   bit          have_prev = 0;
   stim_t       cur;

   function automatic logic [10:0] model_ctl(input stim_t s);
      bit load_use, mem_wait, div_wait, exc, go, cancel;
      logic [4:0] st;
      logic [3:0] fl;
      if (s.rst) return 11'd0;
      load_use = s.mem_to_regE && (s.reg_writeE != 0) &&
                 (s.reg_writeE == s.rsD || s.reg_writeE == s.rtD);
      mem_wait = s.data_reqM && !s.data_ok && !mem_held;
      div_wait = s.div_reqE && !s.div_done && (div_state != 2);
      exc      = s.exceptM && !mem_wait;
      if (exc)           begin st = 5'b00000; fl = 4'b1111; end
      else if (mem_wait) begin st = 5'b11111; fl = 4'b0000; end
      else if (div_wait) begin st = 5'b11100; fl = 4'b0010; end
      else if (load_use) begin st = 5'b11000; fl = 4'b0100; end
      else               begin st = 5'b00000; fl = 4'b0000; end
      go     = s.div_reqE && (div_state == 0) && !exc;
      cancel = exc && (div_state == 1);
      return {st, fl, go, cancel};
   endfunction

   task automatic advance(input stim_t s, input logic [10:0] c);
      bit stF, stE, stM, go, exc;
      stF = c[10]; stE = c[8]; stM = c[7]; exc = c[2]; go = c[1];
      if (s.rst) begin
         div_state = 0;
         mem_held  = 0;
         cnt_m     = 32'd0;
      end else begin
         cnt_m = cnt_m + (stF ? 32'd1 : 32'd0);
         if (exc) begin
            div_state = 0;
            mem_held  = 0;
         end else begin
            if (s.div_done)          div_state = stE ? 2 : 0;
            else if (div_state == 2) div_state = stE ? 2 : 0;
            else if (go)             div_state = 1;
            mem_held = stM && (mem_held || s.data_ok);
         end
      end
   endtask

   task automatic drive(input stim_t s);
      logic [10:0] c;
      exp_t        e;
      @(posedge clk);
      #1;
      if (have_prev) advance(prev, prev_ctl);
      rst            = s.rst;
      ps.rsD         = s.rsD;
      ps.rtD         = s.rtD;
      ps.reg_writeE  = s.reg_writeE;
      ps.mem_to_regE = s.mem_to_regE;
      ps.div_reqE    = s.div_reqE;
      ps.div_done    = s.div_done;
      ps.data_reqM   = s.data_reqM;
      ps.data_ok     = s.data_ok;
      ps.exceptM     = s.exceptM;
      c       = model_ctl(s);
      e.ctl   = c;
      e.cnt   = cnt_m;
      exp_q.push_back(e);
      prev     = s;
      prev_ctl = c;
      have_prev = 1;
   endtask

   // Monitor: compares the DUT outputs mid-cycle against the queued expectation.
   initial begin
      exp_t        e;
      logic [10:0] got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {ps.stallF, ps.stallD, ps.stallE, ps.stallM, ps.stallW,
                   ps.flushD, ps.flushE, ps.flushM, ps.flushW, ps.div_go, ps.div_cancel};
            checks++;
            if (got !== e.ctl) begin
               errors++;
               $display("FAIL ctl @%0t: got %b expected %b", $time, got, e.ctl);
            end
`ifdef STALL_CNT_EN
            checks++;
            if (stall_cycles !== e.cnt) begin
               errors++;
               $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time, stall_cycles, e.cnt);
            end
`endif
         end
      end
   end

   initial begin
      rst = 1'b1;
      ps.rsD = '0; ps.rtD = '0; ps.reg_writeE = '0;
      ps.mem_to_regE = 1'b0; ps.div_reqE = 1'b0; ps.div_done = 1'b0;
      ps.data_reqM = 1'b0; ps.data_ok = 1'b0; ps.exceptM = 1'b0;

      cur = '0; cur.rst = 1'b1;
      drive(cur); drive(cur);
      cur = '0; drive(cur);

      // Load-use hazard, then same pattern against $zero
      cur.mem_to_regE = 1'b1; cur.reg_writeE = 5'd8; cur.rsD = 5'd8; drive(cur);
      cur = '0; drive(cur);
      cur.mem_to_regE = 1'b1; cur.reg_writeE = 5'd0; cur.rsD = 5'd0; drive(cur);
      cur = '0; drive(cur);

      // 35-cycle divide
      cur.div_reqE = 1'b1;
      repeat (35) drive(cur);
      cur.div_done = 1'b1; drive(cur);
      cur = '0; drive(cur);

      // SRAM wait of 3 cycles, then 0-wait access
      cur.data_reqM = 1'b1;
      repeat (3) drive(cur);
      cur.data_ok = 1'b1; drive(cur);
      cur = '0; drive(cur);
      cur.data_reqM = 1'b1; cur.data_ok = 1'b1; drive(cur);
      cur = '0; drive(cur);

      // Divider finishes while memory holds the pipe
      cur.div_reqE = 1'b1; drive(cur);
      cur.data_reqM = 1'b1; drive(cur); drive(cur);
      cur.div_done = 1'b1; drive(cur);
      cur.div_done = 1'b0; drive(cur); drive(cur);
      cur.data_ok = 1'b1; drive(cur);
      cur = '0; drive(cur); drive(cur);

      // Exception cancels a running division
      cur.div_reqE = 1'b1;
      repeat (3) drive(cur);
      cur.exceptM = 1'b1; drive(cur);
      cur = '0; drive(cur);

      // Exception deferred behind an SRAM wait
      cur.data_reqM = 1'b1; cur.exceptM = 1'b1;
      drive(cur); drive(cur);
      cur.data_ok = 1'b1; drive(cur);
      cur = '0; drive(cur);

      // Reset in the middle of a division after 10 stall cycles
      cur.rst = 1'b1; drive(cur);
      cur = '0; cur.div_reqE = 1'b1;
      repeat (10) drive(cur);
      cur.rst = 1'b1; drive(cur);
      cur = '0; drive(cur); drive(cur);

      // Random traffic with small register numbers so hazards hit often
      for (int i = 0; i < 3000; i++) begin
         cur.rst         = ($urandom_range(0, 99) < 2);
         cur.rsD         = 5'($urandom_range(0, 3));
         cur.rtD         = 5'($urandom_range(0, 3));
         cur.reg_writeE  = 5'($urandom_range(0, 3));
         cur.mem_to_regE = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 99) < 15) cur.div_reqE = ~cur.div_reqE;
         cur.div_done    = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 99) < 25) cur.data_reqM = ~cur.data_reqM;
         cur.data_ok     = ($urandom_range(0, 99) < 30);
         cur.exceptM     = ($urandom_range(0, 99) < 5);
         drive(cur);
      end
      cur = '0; drive(cur);

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
